// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline stage registers (IF_ID and its successors).
package pipeline_pkg;
  localparam int NB_DEF    = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_HELD  = 2'd2
  } stage_state_e;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter, falling-edge clocked, synchronous clear.
module sat_counter #(
  parameter int CNT_W = pipeline_pkg::CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt
);
  always_ff @(negedge i_clk) begin
    if (i_clr)                   o_cnt <= '0;
    else if (i_en && o_cnt != '1) o_cnt <= o_cnt + CNT_W'(1);
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with step gating, stall hold, flush-to-bubble and statistics.
module pipe_stage_reg
  import pipeline_pkg::*;
#(
  parameter int                     NB     = NB_DEF,
  parameter int                     NFIELD = 2,
  parameter logic [NFIELD*NB-1:0]   BUBBLE = '0,
  parameter int                     CNT_W  = CNT_W_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic                 i_valid,
  input  logic [NFIELD*NB-1:0] i_data,
  output logic [NFIELD*NB-1:0] o_data,
  output logic                 o_valid,
  output logic [1:0]           o_state,
  output logic [CNT_W-1:0]     o_stall_cnt,
  output logic [CNT_W-1:0]     o_flush_cnt
);
  stage_state_e state;
  logic         stall_en, flush_en;

  // Flush outranks stall, so a squashed stall is not counted.
  assign stall_en = i_step & i_stall & ~i_flush;
  assign flush_en = i_step & i_flush & o_valid;

  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      o_data  <= BUBBLE;
      o_valid <= 1'b0;
      state   <= ST_EMPTY;
    end else if (i_step) begin
      if (i_flush) begin
        o_data  <= BUBBLE;
        o_valid <= 1'b0;
        state   <= ST_EMPTY;
      end else if (i_stall) begin
        state   <= ST_HELD;
      end else begin
        o_data  <= i_data;
        o_valid <= i_valid;
        state   <= i_valid ? ST_FULL : ST_EMPTY;
      end
    end
  end

  assign o_state = state;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk (i_clk),
    .i_clr (i_reset),
    .i_en  (stall_en),
    .o_cnt (o_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_clk (i_clk),
    .i_clr (i_reset),
    .i_en  (flush_en),
    .o_cnt (o_flush_cnt)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized bench for pipe_stage_reg against a behavioural model; a CNT_W=2 copy covers saturation.
module tb_pipe_stage_reg;
  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1, i_step = 1'b0, i_stall = 1'b0, i_flush = 1'b0, i_valid = 1'b0;
  logic [63:0] i_data = '0;
  logic [63:0] o_data, o_data2;
  logic        o_valid, o_valid2;
  logic [1:0]  o_state, o_state2;
  logic [15:0] o_stall_cnt, o_flush_cnt;
  logic [1:0]  o_stall_cnt2, o_flush_cnt2;

  int vectors = 0;
  int miscompares = 0;

  // Model state
  logic [63:0] m_data;
  logic        m_valid;
  int          m_state, m_scnt, m_fcnt, m_scnt2, m_fcnt2;
  bit          m_init = 0;

  always #5 i_clk = ~i_clk;

  pipe_stage_reg dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_step(i_step), .i_stall(i_stall),
    .i_flush(i_flush), .i_valid(i_valid), .i_data(i_data),
    .o_data(o_data), .o_valid(o_valid), .o_state(o_state),
    .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
  );

  pipe_stage_reg #(.CNT_W(2)) dut2 (
    .i_clk(i_clk), .i_reset(i_reset), .i_step(i_step), .i_stall(i_stall),
    .i_flush(i_flush), .i_valid(i_valid), .i_data(i_data),
    .o_data(o_data2), .o_valid(o_valid2), .o_state(o_state2),
    .o_stall_cnt(o_stall_cnt2), .o_flush_cnt(o_flush_cnt2)
  );

  function automatic int sat(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one vector: drive after the rising edge, update the model at the falling edge, compare 1ns later.
  task automatic cyc(input logic r, s, st, f, v, input logic [63:0] d);
    @(posedge i_clk);
    i_reset = r; i_step = s; i_stall = st; i_flush = f; i_valid = v; i_data = d;
    @(negedge i_clk);
    #1;
    if (r) begin
      m_data = '0; m_valid = 0; m_state = 0;
      m_scnt = 0; m_fcnt = 0; m_scnt2 = 0; m_fcnt2 = 0; m_init = 1;
    end else if (s && m_init) begin
      if (f) begin
        if (m_valid) begin m_fcnt = sat(m_fcnt, 65535); m_fcnt2 = sat(m_fcnt2, 3); end
        m_data = '0; m_valid = 0; m_state = 0;
      end else if (st) begin
        m_scnt = sat(m_scnt, 65535); m_scnt2 = sat(m_scnt2, 3); m_state = 2;
      end else begin
        m_data = d; m_valid = v; m_state = v ? 1 : 0;
      end
    end
    vectors++;
    if (m_init) begin
      chk("data",       o_data,       m_data);
      chk("valid",      64'(o_valid), 64'(m_valid));
      chk("state",      64'(o_state), 64'(m_state));
      chk("stall_cnt",  64'(o_stall_cnt), 64'(m_scnt));
      chk("flush_cnt",  64'(o_flush_cnt), 64'(m_fcnt));
      chk("data2",      o_data2,      m_data);
      chk("valid2",     64'(o_valid2), 64'(m_valid));
      chk("state2",     64'(o_state2), 64'(m_state));
      chk("stall_cnt2", 64'(o_stall_cnt2), 64'(m_scnt2));
      chk("flush_cnt2", 64'(o_flush_cnt2), 64'(m_fcnt2));
    end
  endtask

  initial begin
    // Reset state
    cyc(1, 0, 0, 0, 0, 64'hDEAD_BEEF_0000_0001);
    chk("rst_data", o_data, 64'h0);
    chk("rst_state", 64'(o_state), 64'd0);
    chk("rst_cnt", 64'(o_stall_cnt), 64'd0);

    // Load
    cyc(0, 1, 0, 0, 1, {32'h4, 32'h2002_0005});
    chk("load_data", o_data, 64'h0000_0004_2002_0005);
    chk("load_valid", 64'(o_valid), 64'd1);
    chk("load_state", 64'(o_state), 64'd1);

    // Stall three stepped edges with changing input
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 1, {$urandom, $urandom});
    chk("stall_data", o_data, 64'h0000_0004_2002_0005);
    chk("stall_cnt3", 64'(o_stall_cnt), 64'd3);
    chk("stall_state", 64'(o_state), 64'd2);

    // Reload to FULL, then flush together with stall
    cyc(0, 1, 0, 0, 1, 64'h0000_0008_1234_5678);
    cyc(0, 1, 1, 1, 1, 64'h1111_2222_3333_4444);
    chk("fs_data", o_data, 64'h0);
    chk("fs_valid", 64'(o_valid), 64'd0);
    chk("fs_fcnt", 64'(o_flush_cnt), 64'd1);
    chk("fs_scnt", 64'(o_stall_cnt), 64'd3);
    chk("fs_state", 64'(o_state), 64'd0);

    // Flush of an empty stage does not count
    cyc(0, 1, 0, 1, 1, 64'h5);
    chk("flush_empty_fcnt", 64'(o_flush_cnt), 64'd1);

    // Step gating
    cyc(0, 1, 0, 0, 1, 64'hABC);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, {$urandom, $urandom});
    chk("gate_data", o_data, 64'hABC);
    chk("gate_valid", 64'(o_valid), 64'd1);
    chk("gate_fcnt", 64'(o_flush_cnt), 64'd1);

    // Saturation on the CNT_W=2 copy
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 0, 64'h0);
    chk("sat_scnt2", 64'(o_stall_cnt2), 64'd3);
    chk("sat_scnt", 64'(o_stall_cnt), 64'd9);

    // Reset while HELD with step low
    cyc(1, 0, 1, 0, 1, 64'h77);
    chk("rst_held_state", 64'(o_state), 64'd0);
    chk("rst_held_data", o_data, 64'h0);
    chk("rst_held_scnt", 64'(o_stall_cnt), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 80),
          ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 15),
          ($urandom_range(0, 99) < 70), {$urandom, $urandom});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter NB, 32, width of one payload field in bits.
REQ-002 Parameter NFIELD, 2, number of payload fields carried (e.g. pc4 and instruction).
REQ-003 Parameter BUBBLE, {NFIELD*NB{1'b0}}, payload value loaded on flush or reset.
REQ-004 Parameter CNT_W, 16, width of each statistics counter.
REQ-005 i_clk  input  1  clock; all state updates on the falling edge.
REQ-006 i_reset  input  1  reset, synchronous, active-high.
REQ-007 i_step  input  1  debug-unit step enable; low freezes all state.
REQ-008 i_stall  input  1  hazard-unit hold request.
REQ-009 i_flush  input  1  branch/jump squash request.
REQ-010 i_valid  input  1  upstream payload is a real instruction.
REQ-011 i_data  input  NFIELD*NB  upstream payload; field k at bits [k*NB +: NB].
REQ-012 o_data  output  NFIELD*NB  registered payload.
REQ-013 o_valid  output  1  registered payload is a real instruction.
REQ-014 o_state  output  2  FSM state encoding, for the debug unit.
REQ-015 o_stall_cnt  output  CNT_W  count of stepped cycles held by stall.
REQ-016 o_flush_cnt  output  CNT_W  count of flushes that squashed a valid instruction.

Function
REQ-017 All updates SHALL occur on negedge i_clk, and only when i_step=1 or i_reset=1.
REQ-018 With i_step=0, o_data, o_valid, state and counters SHALL hold unchanged regardless of i_stall/i_flush.
REQ-019 Priority per stepped edge SHALL be: i_flush > i_stall > load.
REQ-020 Load: o_data<=i_data, o_valid<=i_valid; latency one falling edge.
REQ-021 Stall: o_data and o_valid hold; o_stall_cnt increments.
REQ-022 Flush: o_data<=BUBBLE, o_valid<=0; o_flush_cnt increments only if o_valid was 1 before the edge.
REQ-023 Flush concurrent with stall SHALL flush (bubble wins) and SHALL NOT increment o_stall_cnt.
REQ-024 FSM states: EMPTY(0) o_valid=0 not held; FULL(1) o_valid=1 not held; HELD(2) stall active last edge.
REQ-025 Transitions: any->EMPTY on flush or load with i_valid=0; any->FULL on load with i_valid=1; any->HELD on stall without flush; HELD exits by load or flush only.
REQ-026 Counters SHALL saturate at all-ones, never wrap.
REQ-027 No combinational path from any input to any output.

Reset
REQ-028 On i_reset=1 at a falling edge: o_data=BUBBLE, o_valid=0, o_state=EMPTY, both counters 0, irrespective of i_step, i_stall, i_flush.
REQ-029 Reset asserted mid-stall SHALL clear HELD immediately; first stepped edge after reset follows REQ-019.

Structure
REQ-030 State encodings and default NB/CNT_W SHALL live in shared package pipeline_pkg for reuse by ID_EX, EX_MEM, MEM_WB successors.
REQ-031 One sub-module sat_counter (CNT_W, enable, synchronous clear) SHALL be instantiated twice.

Verification
REQ-032 Load: step=1, i_data={32'h4,32'h2002_0005}, valid=1 -> after one negedge o_data equal, o_valid=1, o_state=FULL.
REQ-033 Stall: FULL, stall=1 for 3 stepped edges, i_data changing -> o_data unchanged, o_stall_cnt=3, o_state=HELD.
REQ-034 Flush+stall: FULL, stall=1 and flush=1 same edge -> o_data=0, o_valid=0, o_flush_cnt=1, o_stall_cnt unchanged, EMPTY.
REQ-035 Step gating: step=0, flush=1, new i_data for 5 edges -> no output or counter change.
REQ-036 Saturation: CNT_W=2, stall 6 stepped edges -> o_stall_cnt stays 3.
REQ-037 Reset mid-stall: HELD, reset=1 with step=0 -> all outputs reset, EMPTY, counters 0.
